// File: rtl/zx_port_fe.sv
// zx_port_fe: Spectrum port #FE (border/MIC/beeper latch, key matrix read)
// with a PS/2 set-2 receiver and scan-code decoder feeding an 8x5 ZX matrix.
//
// Ports:
//   clk, reset_n        system clock, async active-low reset
//   ps2_clk, ps2_dat    raw asynchronous PS/2 pins
//   io_addr/io_wdata    CPU I/O address and write data
//   io_wr               one-cycle I/O write strobe
//   io_rdata            registered port #FE read data
//   ear                 tape input, returned in read bit 6
//   border/mic/beeper   latched write bits
//   kbd_err             one-cycle pulse on framing/parity/timeout error
module zx_port_fe #(
  parameter int TIMEOUT_CYCLES = 2500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  input  logic [15:0] io_addr,
  input  logic [7:0]  io_wdata,
  input  logic        io_wr,
  output logic [7:0]  io_rdata,
  input  logic        ear,
  output logic [2:0]  border,
  output logic        mic,
  output logic        beeper,
  output logic        kbd_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE, GOT_F0, GOT_E0, GOT_E0F0
  } dec_st_e;

  // ---------------- port write latch ----------------
  logic [2:0] border_q;
  logic       mic_q, beeper_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      border_q <= '0;
      mic_q    <= 1'b0;
      beeper_q <= 1'b0;
    end else if (io_wr && !io_addr[0]) begin
      border_q <= io_wdata[2:0];
      mic_q    <= io_wdata[3];
      beeper_q <= io_wdata[4];
    end
  end

  assign border = border_q;
  assign mic    = mic_q;
  assign beeper = beeper_q;

  logic unused_in;
  assign unused_in = ^{io_addr[7:1], io_wdata[7:5]};

  // ---------------- PS/2 synchronizer ----------------
  // Bit 0 is the newest sample; idle level of both pins is high.
  logic [2:0] pc_q, pd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= 3'b111;
      pd_q <= 3'b111;
    end else begin
      pc_q <= {pc_q[1:0], ps2_clk};
      pd_q <= {pd_q[1:0], ps2_dat};
    end
  end

  logic fall, bit_in;
  assign fall   = pc_q[2] & ~pc_q[1];
  assign bit_in = pd_q[1];

  // ---------------- PS/2 frame receiver ----------------
  // cnt 0 waits for start, 1..9 shift data+parity, 10 checks stop.
  logic [3:0]    cnt_q, cnt_d;
  logic [8:0]    sh_q, sh_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          err_q, err_d;
  logic          vld_q, vld_d;
  logic [7:0]    byte_q, byte_d;

  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    idle_d = idle_q;
    err_d  = 1'b0;
    vld_d  = 1'b0;
    byte_d = byte_q;
    if (fall) begin
      idle_d = '0;
      unique case (1'b1)
        cnt_q == 4'd0: begin
          if (!bit_in) cnt_d = 4'd1;
          else         err_d = 1'b1;
        end
        cnt_q >= 4'd1 && cnt_q <= 4'd9: begin
          sh_d  = {bit_in, sh_q[8:1]};
          cnt_d = cnt_q + 4'd1;
        end
        default: begin
          // odd parity: data plus parity bit has an odd count of ones
          if (bit_in && ^sh_q) begin
            vld_d  = 1'b1;
            byte_d = sh_q[7:0];
          end else begin
            err_d = 1'b1;
          end
          cnt_d = 4'd0;
        end
      endcase
    end else if (cnt_q != 4'd0) begin
      if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
        err_d  = 1'b1;
        cnt_d  = 4'd0;
        idle_d = '0;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end else begin
      idle_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      sh_q   <= '0;
      idle_q <= '0;
      err_q  <= 1'b0;
      vld_q  <= 1'b0;
      byte_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      idle_q <= idle_d;
      err_q  <= err_d;
      vld_q  <= vld_d;
      byte_q <= byte_d;
    end
  end

  assign kbd_err = err_q;

  // ---------------- scan-code decoder FSM ----------------
  dec_st_e st_q, st_d;
  logic    is_f0, is_e0;
  logic    apply, brk, ext;

  assign is_f0 = byte_q == 8'hF0;
  assign is_e0 = byte_q == 8'hE0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st_q <= IDLE;
    else          st_q <= st_d;
  end

  // Prefixes accumulate so F0 after E0 (or vice versa) lands in GOT_E0F0.
  always_comb begin
    st_d = st_q;
    if (err_q) begin
      st_d = IDLE;
    end else if (vld_q) begin
      unique case (1'b1)
        is_f0:
          st_d = (st_q == GOT_E0 || st_q == GOT_E0F0) ? GOT_E0F0 : GOT_F0;
        is_e0:
          st_d = (st_q == GOT_F0 || st_q == GOT_E0F0) ? GOT_E0F0 : GOT_E0;
        default:
          st_d = IDLE;
      endcase
    end
  end

  always_comb begin
    apply = vld_q && !is_f0 && !is_e0;
    brk   = st_q == GOT_F0 || st_q == GOT_E0F0;
    ext   = st_q == GOT_E0 || st_q == GOT_E0F0;
  end

  // ---------------- key flags ----------------
  // Direct keys index row*5+bit; returns {hit, index}.
  function automatic logic [6:0] map_key(input logic [7:0] c);
    unique case (c)
      8'h1A: map_key = {1'b1, 6'd1};
      8'h22: map_key = {1'b1, 6'd2};
      8'h21: map_key = {1'b1, 6'd3};
      8'h2A: map_key = {1'b1, 6'd4};
      8'h1C: map_key = {1'b1, 6'd5};
      8'h1B: map_key = {1'b1, 6'd6};
      8'h23: map_key = {1'b1, 6'd7};
      8'h2B: map_key = {1'b1, 6'd8};
      8'h34: map_key = {1'b1, 6'd9};
      8'h15: map_key = {1'b1, 6'd10};
      8'h1D: map_key = {1'b1, 6'd11};
      8'h24: map_key = {1'b1, 6'd12};
      8'h2D: map_key = {1'b1, 6'd13};
      8'h2C: map_key = {1'b1, 6'd14};
      8'h16: map_key = {1'b1, 6'd15};
      8'h1E: map_key = {1'b1, 6'd16};
      8'h26: map_key = {1'b1, 6'd17};
      8'h25: map_key = {1'b1, 6'd18};
      8'h2E: map_key = {1'b1, 6'd19};
      8'h45: map_key = {1'b1, 6'd20};
      8'h46: map_key = {1'b1, 6'd21};
      8'h3E: map_key = {1'b1, 6'd22};
      8'h3D: map_key = {1'b1, 6'd23};
      8'h36: map_key = {1'b1, 6'd24};
      8'h4D: map_key = {1'b1, 6'd25};
      8'h44: map_key = {1'b1, 6'd26};
      8'h43: map_key = {1'b1, 6'd27};
      8'h3C: map_key = {1'b1, 6'd28};
      8'h35: map_key = {1'b1, 6'd29};
      8'h5A: map_key = {1'b1, 6'd30};
      8'h4B: map_key = {1'b1, 6'd31};
      8'h42: map_key = {1'b1, 6'd32};
      8'h3B: map_key = {1'b1, 6'd33};
      8'h33: map_key = {1'b1, 6'd34};
      8'h29: map_key = {1'b1, 6'd35};
      8'h14: map_key = {1'b1, 6'd36};
      8'h3A: map_key = {1'b1, 6'd37};
      8'h31: map_key = {1'b1, 6'd38};
      8'h32: map_key = {1'b1, 6'd39};
      default: map_key = 7'd0;
    endcase
  endfunction

  // cmp: 0 LShift, 1 RShift, 2 Backspace, 3 left, 4 down, 5 up, 6 right
  logic [39:0] keys_q, keys_d;
  logic [6:0]  cmp_q, cmp_d;
  logic [6:0]  hit;

  always_comb begin
    keys_d = keys_q;
    cmp_d  = cmp_q;
    hit    = map_key(byte_q);
    if (apply) begin
      if (ext) begin
        unique case (byte_q)
          8'h6B: cmp_d[3] = ~brk;
          8'h72: cmp_d[4] = ~brk;
          8'h75: cmp_d[5] = ~brk;
          8'h74: cmp_d[6] = ~brk;
          default: ;
        endcase
      end else begin
        unique case (byte_q)
          8'h12: cmp_d[0] = ~brk;
          8'h59: cmp_d[1] = ~brk;
          8'h66: cmp_d[2] = ~brk;
          default: begin
            for (int i = 0; i < 40; i++)
              if (hit[6] && hit[5:0] == 6'(i)) keys_d[i] = ~brk;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      keys_q <= '0;
      cmp_q  <= '0;
    end else begin
      keys_q <= keys_d;
      cmp_q  <= cmp_d;
    end
  end

  // ---------------- matrix and read port ----------------
  logic [39:0] mat;
  logic [4:0]  rows_or;
  logic [7:0]  rdata_d, rdata_q;

  always_comb begin
    mat     = keys_q;
    mat[0]  = keys_q[0]  | (|cmp_q);
    mat[20] = keys_q[20] | cmp_q[2];
    mat[19] = keys_q[19] | cmp_q[3];
    mat[24] = keys_q[24] | cmp_q[4];
    mat[23] = keys_q[23] | cmp_q[5];
    mat[22] = keys_q[22] | cmp_q[6];
  end

  always_comb begin
    rows_or = '0;
    for (int r = 0; r < 8; r++)
      if (!io_addr[8+r]) rows_or = rows_or | mat[r*5 +: 5];
    rdata_d = io_addr[0] ? 8'hFF : {1'b1, ear, 1'b1, ~rows_or};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= 8'hFF;
    else          rdata_q <= rdata_d;
  end

  assign io_rdata = rdata_q;

endmodule

// File: tb/tb_zx_port_fe.sv
// tb_zx_port_fe: directed bench for zx_port_fe.
// Drives CPU writes/reads and bit-banged PS/2 frames, checks hand-computed values.
module tb_zx_port_fe;

  localparam int TO = 2500;
  localparam int HP = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [15:0] io_addr = 16'h00FF;
  logic [7:0]  io_wdata = '0;
  logic        io_wr = 1'b0;
  logic [7:0]  io_rdata;
  logic        ear = 1'b0;
  logic [2:0]  border;
  logic        mic, beeper, kbd_err;

  int checks = 0;
  int errors = 0;
  int errs = 0;
  int e0;

  always #5 clk = ~clk;

  zx_port_fe #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_wr(io_wr),
    .io_rdata(io_rdata), .ear(ear),
    .border(border), .mic(mic), .beeper(beeper),
    .kbd_err(kbd_err)
  );

  always @(negedge clk) if (kbd_err === 1'b1) errs++;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    io_addr = a; io_wdata = d; io_wr = 1'b1;
    cyc(1);
    io_wr = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a,
                    input logic [7:0] exp);
    io_addr = a;
    cyc(1);
    check(tag, {8'h00, io_rdata}, {8'h00, exp});
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    cyc(HP);
    ps2_clk = 1'b0;
    cyc(HP);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] c, input logic badpar);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(c[i]);
    ps2_bit(~^c ^ badpar);
    ps2_bit(1'b1);
    cyc(HP);
  endtask

  task automatic key(input logic [7:0] c);
    send(c, 1'b0);
  endtask

  initial begin
    cyc(3);
    check("rst_border", {13'd0, border}, 16'd0);
    check("rst_mic", {15'd0, mic}, 16'd0);
    check("rst_beeper", {15'd0, beeper}, 16'd0);
    check("rst_rdata", {8'd0, io_rdata}, 16'h00FF);
    check("rst_err", {15'd0, kbd_err}, 16'd0);
    reset_n = 1'b1;
    cyc(2);

    wr(16'h00FE, 8'h15);
    check("wr_border", {13'd0, border}, 16'd5);
    check("wr_mic", {15'd0, mic}, 16'd0);
    check("wr_beeper", {15'd0, beeper}, 16'd1);
    rd("rd_odd", 16'h00FF, 8'hFF);
    rd("rd_empty", 16'h00FE, 8'hBF);
    ear = 1'b1;
    rd("rd_ear", 16'h00FE, 8'hFF);
    ear = 1'b0;

    wr(16'h00FF, 8'h07);
    check("wr_odd_ign", {13'd0, border}, 16'd5);
    wr(16'h1234, 8'h0A);
    check("wr_hi_border", {13'd0, border}, 16'd2);
    check("wr_hi_mic", {15'd0, mic}, 16'd1);
    io_wr = 1'b1; io_addr = 16'h00FE; io_wdata = 8'h01;
    cyc(1);
    io_wdata = 8'h06;
    cyc(1);
    io_wr = 1'b0;
    check("b2b_border", {13'd0, border}, 16'd6);
    check("b2b_mic", {15'd0, mic}, 16'd0);

    key(8'h1C);
    rd("a_make", 16'hFDFE, 8'hBE);
    key(8'hF0); key(8'h1C);
    rd("a_break", 16'hFDFE, 8'hBF);
    key(8'h1C); key(8'h1C);
    key(8'hF0); key(8'h1C);
    rd("typematic", 16'hFDFE, 8'hBF);
    key(8'hF0); key(8'h1B);
    rd("brk_noop", 16'hFDFE, 8'hBF);

    key(8'h12);
    key(8'hE0); key(8'h75);
    rd("up_cs", 16'hFEFE, 8'hBE);
    rd("up_7", 16'hEFFE, 8'hB7);
    key(8'hE0); key(8'hF0); key(8'h75);
    rd("up_rel_cs", 16'hFEFE, 8'hBE);
    rd("up_rel_7", 16'hEFFE, 8'hBF);

    e0 = errs;
    send(8'h1A, 1'b1);
    check("par_err", 16'(errs - e0), 16'd1);
    rd("par_nochg", 16'hFEFE, 8'hBE);

    e0 = errs;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_dat = 1'b1;
    cyc(TO + 100);
    check("timeout_err", 16'(errs - e0), 16'd1);
    key(8'h16);
    rd("after_to", 16'hF7FE, 8'hBE);

    key(8'h66);
    rd("bksp_0", 16'hEFFE, 8'hBE);
    key(8'hF0); key(8'h66);
    key(8'h59);
    key(8'hF0); key(8'h12);
    rd("rshift_held", 16'hFEFE, 8'hBE);
    key(8'hF0); key(8'h59);
    rd("cs_clear", 16'hFEFE, 8'hBF);
    key(8'hF0); key(8'h16);

    key(8'h29); key(8'h32);
    rd("space_b", 16'h00FE, 8'hAE);
    check("err_total", 16'(errs), 16'd2);

    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    ps2_bit(1'b0); ps2_bit(1'b0);
    reset_n = 1'b0;
    ps2_dat = 1'b1;
    cyc(2);
    check("mrst_border", {13'd0, border}, 16'd0);
    check("mrst_beeper", {15'd0, beeper}, 16'd0);
    check("mrst_rdata", {8'd0, io_rdata}, 16'h00FF);
    check("mrst_err", {15'd0, kbd_err}, 16'd0);
    reset_n = 1'b1;
    cyc(2);
    rd("mrst_mat", 16'h00FE, 8'hBF);
    key(8'h1C);
    rd("mrst_frame", 16'h00FE, 8'hBE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
